// File: rtl/booth_arb_pkg.sv
// Shared definitions for the booth multiplier arbiter: FSM state encoding,
// default widths and an index-width helper.
package booth_arb_pkg;

    localparam int D_IN_DEF        = 8;
    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REL  = 2'd2
    } arb_state_e;

    // Bits needed to hold an index in 0..n-1; never less than one bit so a
    // single-requester build still has a legal pointer register.
    function automatic int idx_width(input int n);
        for (int w = 1; w < 31; w++) begin
            if ((32'sd1 << w) >= n) begin
                return w;
            end
        end
        return 31;
    endfunction

endpackage

// File: rtl/booth_rr_pick.sv
// Rotating-priority picker: returns the first set request bit found when
// scanning upward from the pointer, wrapping at N_REQ.
module booth_rr_pick
    import booth_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] rot_s;

    // Scan N_REQ positions from ptr; the first hit wins, later hits are ignored.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        rot_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot_s = {1'b0, ptr} + (IDX_W+1)'(k);
            rot_s = (rot_s >= (IDX_W+1)'(N_REQ)) ? (rot_s - (IDX_W+1)'(N_REQ)) : rot_s;
            idx   = (!valid && req[rot_s[IDX_W-1:0]]) ? rot_s[IDX_W-1:0] : idx;
            valid = valid | req[rot_s[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one booth multiplier among N_REQ
// requesters. The winner's operands are latched, start is held until done,
// and the product is returned with a one-cycle ack.
// Optional watchdog: define BOOTH_ARB_TIMEOUT_EN to abort a RUN that sees no
// done within TIMEOUT_CYC cycles (ack with zero product plus an err pulse).
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int D_IN        = D_IN_DEF,
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*D_IN-1:0] req_a,
    input  logic [N_REQ*D_IN-1:0] req_b,
    output logic [N_REQ-1:0]      ack,
    output logic [2*D_IN-1:0]     rsp_product,
    output logic                  busy,
    output logic                  err,
    output logic                  mul_start,
    output logic [D_IN-1:0]       mul_A,
    output logic [D_IN-1:0]       mul_B,
    input  logic                  mul_done,
    input  logic [2*D_IN-1:0]     mul_product
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_e           state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     winner_r;
    logic [N_REQ-1:0]     ack_r;
    logic [2*D_IN-1:0]    rsp_product_r;
    logic                 busy_r;
    logic                 mul_start_r;
    logic [D_IN-1:0]      mul_a_r;
    logic [D_IN-1:0]      mul_b_r;

    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [D_IN-1:0]      sel_a_s;
    logic [D_IN-1:0]      sel_b_s;
    logic [IDX_W-1:0]     ptr_next_s;
    logic [N_REQ-1:0]     ack_hot_s;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_width(TIMEOUT_CYC);
    logic [CNT_W-1:0]     wdog_cnt_r;
    logic                 err_r;
    logic                 wdog_hit_s;

    // The counter holds the number of completed RUN cycles; the last allowed
    // cycle is the one where it reads TIMEOUT_CYC-1.
    assign wdog_hit_s = (wdog_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    assign err        = err_r;
`else
    assign err        = 1'b0;
`endif

    booth_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Operand mux for the requester the picker currently selects.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s = (pick_idx_s == IDX_W'(i)) ? req_a[i*D_IN +: D_IN] : sel_a_s;
            sel_b_s = (pick_idx_s == IDX_W'(i)) ? req_b[i*D_IN +: D_IN] : sel_b_s;
        end
    end

    // Next pointer (one past the winner, wrapping) and the winner's ack vector.
    always_comb begin
        ptr_next_s = (winner_r == IDX_W'(N_REQ - 1)) ? '0 : (winner_r + IDX_W'(1));
        ack_hot_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack_hot_s[i] = (winner_r == IDX_W'(i));
        end
    end

    // Sequencer FSM: grant in IDLE, wait for done in RUN, release in REL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            winner_r      <= '0;
            ack_r         <= '0;
            rsp_product_r <= '0;
            busy_r        <= 1'b0;
            mul_start_r   <= 1'b0;
            mul_a_r       <= '0;
            mul_b_r       <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            wdog_cnt_r    <= '0;
            err_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        winner_r    <= pick_idx_s;
                        mul_a_r     <= sel_a_s;
                        mul_b_r     <= sel_b_s;
                        mul_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
`ifdef BOOTH_ARB_TIMEOUT_EN
                        wdog_cnt_r  <= '0;
`endif
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (mul_done) begin
                        mul_start_r   <= 1'b0;
                        rsp_product_r <= mul_product;
                        ack_r         <= ack_hot_s;
                        ptr_r         <= ptr_next_s;
                        state_r       <= ST_REL;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    end else if (wdog_hit_s) begin
                        mul_start_r   <= 1'b0;
                        rsp_product_r <= '0;
                        ack_r         <= ack_hot_s;
                        err_r         <= 1'b1;
                        ptr_r         <= ptr_next_s;
                        state_r       <= ST_REL;
                    end else begin
                        wdog_cnt_r    <= wdog_cnt_r + CNT_W'(1);
                        state_r       <= ST_RUN;
                    end
`else
                    end else begin
                        state_r       <= ST_RUN;
                    end
`endif
                end
                ST_REL: begin
                    // One cycle with start low and ack cleared so the multiplier
                    // re-arms and the requester can drop req before the next grant.
                    ack_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    err_r   <= 1'b0;
`endif
                end
                default: begin
                    ack_r       <= '0;
                    busy_r      <= 1'b0;
                    mul_start_r <= 1'b0;
                    state_r     <= ST_IDLE;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    err_r       <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign ack         = ack_r;
    assign rsp_product = rsp_product_r;
    assign busy        = busy_r;
    assign mul_start   = mul_start_r;
    assign mul_A       = mul_a_r;
    assign mul_B       = mul_b_r;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter with a fixed-latency multiplier
// stub and a scoreboard of expected (requester, product) pairs.
// Define BOOTH_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_booth_mult_arbiter;

    localparam int D_IN        = 8;
    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int MUL_LAT     = 4;

    typedef struct {
        int          idx;
        logic [15:0] prod;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  ack;
    logic [15:0] rsp_product;
    logic        busy;
    logic        err;
    logic        mul_start;
    logic [7:0]  mul_A;
    logic [7:0]  mul_B;
    logic        mul_done;
    logic [15:0] mul_product;

    logic        stub_done_r;
    logic [15:0] stub_prod_r;
    logic        stub_armed_r;
    logic        stub_run_r;
    int          stub_cnt_r;
    logic        stub_hang;
    logic        spurious_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [7:0]  op_a[4];
    logic [7:0]  op_b[4];
    int          model_ptr;

    always #5 clk = ~clk;

    booth_mult_arbiter #(
        .D_IN        (D_IN),
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .ack         (ack),
        .rsp_product (rsp_product),
        .busy        (busy),
        .err         (err),
        .mul_start   (mul_start),
        .mul_A       (mul_A),
        .mul_B       (mul_B),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    assign mul_done    = stub_done_r | spurious_done;
    assign mul_product = stub_prod_r;

    // Multiplier stub: starts on a start level seen after start was low,
    // pulses done for one cycle MUL_LAT cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_done_r  <= 1'b0;
            stub_prod_r  <= 16'h0000;
            stub_armed_r <= 1'b0;
            stub_run_r   <= 1'b0;
            stub_cnt_r   <= 0;
        end else begin
            stub_done_r <= 1'b0;
            if (!mul_start) begin
                stub_armed_r <= 1'b1;
            end else if (stub_armed_r) begin
                stub_armed_r <= 1'b0;
                stub_run_r   <= 1'b1;
                stub_cnt_r   <= MUL_LAT;
                stub_prod_r  <= $signed(mul_A) * $signed(mul_B);
            end else if (stub_run_r) begin
                if (stub_cnt_r == 1) begin
                    stub_run_r  <= 1'b0;
                    stub_done_r <= !stub_hang;
                end else begin
                    stub_cnt_r  <= stub_cnt_r - 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive_operands();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = op_a[i];
            req_b[i*8 +: 8] = op_b[i];
        end
    endtask

    // Predict the grant order, raise the requests, then pop the scoreboard
    // on every observed ack. With hold=1 requesters keep req up after ack.
    task automatic do_ops(input logic [3:0] mask, input bit hold, input int n_ops);
        logic [3:0]         live;
        logic signed [15:0] p;
        exp_t               e;
        int                 w;
        int                 got;
        int                 cyc;
        bit                 prev_ack;
        live = mask;
        for (int n = 0; n < n_ops; n++) begin
            w = rr_pick(live, model_ptr);
            p = $signed(op_a[w]) * $signed(op_b[w]);
            e.idx  = w;
            e.prod = p;
            sb_q.push_back(e);
            model_ptr = (w + 1) % 4;
            if (!hold) live[w] = 1'b0;
        end
        drive_operands();
        req = mask;
        @(negedge clk);
        check_eq("start_next", {31'd0, mul_start}, 32'd1);
        check_eq("busy_grant", {31'd0, busy}, 32'd1);
        check_eq("grant_a", {24'd0, mul_A}, {24'd0, op_a[sb_q[0].idx]});
        check_eq("grant_b", {24'd0, mul_B}, {24'd0, op_b[sb_q[0].idx]});
        got = 0;
        cyc = 0;
        prev_ack = 1'b0;
        while (got < n_ops && cyc < 2000) begin
            if (prev_ack) check_eq("ack_width", {28'd0, ack}, 32'd0);
            prev_ack = 1'b0;
            if (ack != 4'b0000) begin
                e = sb_q.pop_front();
                check_eq("ack_onehot", {28'd0, ack}, 32'd1 << e.idx);
                check_eq("rsp_product", {16'd0, rsp_product}, {16'd0, e.prod});
                check_eq("start_gap", {31'd0, mul_start}, 32'd0);
                check_eq("err_low", {31'd0, err}, 32'd0);
                got++;
                prev_ack = 1'b1;
                if (!hold) req[e.idx] = 1'b0;
                if (got == n_ops) req = 4'b0000;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("ops_done", got, n_ops);
        check_eq("ack_clear", {28'd0, ack}, 32'd0);
        check_eq("rel_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("idle_start", {31'd0, mul_start}, 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        req_a = 32'd0;
        req_b = 32'd0;
        stub_hang = 1'b0;
        spurious_done = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'd0;
            op_b[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_ack", {28'd0, ack}, 32'd0);
        check_eq("rst_product", {16'd0, rsp_product}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_start", {31'd0, mul_start}, 32'd0);
        check_eq("rst_mul_a", {24'd0, mul_A}, 32'd0);
        check_eq("rst_mul_b", {24'd0, mul_B}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, positive operands.
        op_a[0] = 8'd10;  op_b[0] = 8'd2;
        do_ops(4'b0001, 1'b0, 1);

        // Signed operands: 11 * -5 and -5 * -11.
        op_a[1] = 8'd11;  op_b[1] = 8'hFB;
        do_ops(4'b0010, 1'b0, 1);
        op_a[2] = 8'hFB;  op_b[2] = 8'hF5;
        do_ops(4'b0100, 1'b0, 1);

        // Two simultaneous requests, both 10 * 2.
        op_a[1] = 8'd10;  op_b[1] = 8'd2;
        do_ops(4'b0011, 1'b0, 2);

        // Requester 3 alone moves the pointer back to 0; extremes: 127 * -128.
        op_a[3] = 8'd127; op_b[3] = 8'h80;
        do_ops(4'b1000, 1'b0, 1);

        // All four held continuously: expect 0,1,2,3,0,1.
        op_a[2] = 8'hF9;  op_b[2] = 8'd3;
        do_ops(4'b1111, 1'b1, 6);

        // Stray done while idle must be ignored.
        spurious_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("spur_ack", {28'd0, ack}, 32'd0);
            check_eq("spur_busy", {31'd0, busy}, 32'd0);
        end
        spurious_done = 1'b0;
        @(negedge clk);

        // Reset mid-RUN: requester 3 is granted (pointer 2), then reset.
        op_a[3] = 8'hFD;  op_b[3] = 8'hFD;
        drive_operands();
        req = 4'b1010;
        @(negedge clk);
        check_eq("pre_rst_grant", {24'd0, mul_A}, {24'd0, op_a[3]});
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_start", {31'd0, mul_start}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_ack", {28'd0, ack}, 32'd0);
        @(negedge clk);
        check_eq("midrst_ack2", {28'd0, ack}, 32'd0);
        rst_n = 1'b1;
        model_ptr = 0;
        do_ops(4'b1010, 1'b0, 2);

`ifdef BOOTH_ARB_TIMEOUT_EN
        begin
            int cyc;
            stub_hang = 1'b1;
            op_a[2] = 8'd5;  op_b[2] = 8'd6;
            drive_operands();
            req = 4'b0100;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (ack == 4'b0000 && cyc < 200);
            check_eq("to_latency", cyc, 65);
            check_eq("to_ack", {28'd0, ack}, 32'd4);
            check_eq("to_err", {31'd0, err}, 32'd1);
            check_eq("to_product", {16'd0, rsp_product}, 32'd0);
            req = 4'b0000;
            @(negedge clk);
            check_eq("to_err_pulse", {31'd0, err}, 32'd0);
            check_eq("to_ack_pulse", {28'd0, ack}, 32'd0);
            check_eq("to_busy", {31'd0, busy}, 32'd0);
            stub_hang = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
